// File: rtl/c3lib_ckg_async_multi_hyst_ctn_if.sv
// Request/clock bundle for the multi-channel hysteretic clock gater.
//   tst_en     : scan/test override, forces every gated clock on
//   clk_en     : per-channel enable requests, asynchronous to clk
//   gated_clk  : per-channel gated clocks
//   clk_en_ack : per-channel registered enable (1 = clock running)
//   all_gated  : registered, 1 when every ack bit is 0
// master = requester side, slave = gater side.
interface c3lib_ckg_async_multi_hyst_ctn_if #(
    parameter int unsigned NUM_CH = 4
);
    logic              tst_en;
    logic [NUM_CH-1:0] clk_en;
    logic [NUM_CH-1:0] gated_clk;
    logic [NUM_CH-1:0] clk_en_ack;
    logic              all_gated;

    modport master (
        output tst_en,
        output clk_en,
        input  gated_clk,
        input  clk_en_ack,
        input  all_gated
    );

    modport slave (
        input  tst_en,
        input  clk_en,
        output gated_clk,
        output clk_en_ack,
        output all_gated
    );
endinterface

// File: rtl/c3lib_ckg_async_multi_hyst_ctn.sv
// Multi-channel positive-edge clock gater with per-channel asynchronous
// enables, configurable synchroniser depth and min-on/min-off hysteresis.
// Ports:
//   clk   : root clock, sole clock domain
//   rst_n : asynchronous active-low reset (release synchronous upstream)
//   bus   : slave side of c3lib_ckg_async_multi_hyst_ctn_if
//           (tst_en, clk_en in; gated_clk, clk_en_ack, all_gated out)

// Single-bit synchroniser chain with configurable depth and reset value.
//   clk, rst_n : clock and async active-low reset
//   data_in    : asynchronous input
//   data_out   : synchronised output
module c3lib_bitsync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic data_in,
    output logic data_out
);
    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], data_in};
        end
    end

    assign data_out = sync_q[SYNC_STAGES-1];
endmodule

// Latch-based integrated clock gate.
//   clk       : clock to gate
//   clk_en    : functional enable
//   tst_en    : test override enable
//   gated_clk : gated clock output
module c3lib_ckg_lvt_8x (
    input  logic clk,
    input  logic clk_en,
    input  logic tst_en,
    output logic gated_clk
);
    logic en_l;

    // Transparent while clk is low so the enable is frozen during the high
    // phase and the AND below cannot glitch.
    always_latch begin
        if (!clk) begin
            en_l <= clk_en | tst_en;
        end
    end

    assign gated_clk = clk & en_l;
endmodule

module c3lib_ckg_async_multi_hyst_ctn #(
    parameter int unsigned       NUM_CH      = 4,
    parameter int unsigned       SYNC_STAGES = 2,
    parameter logic [NUM_CH-1:0] RESET_VAL   = '0,
    parameter int unsigned       MIN_ON_CYC  = 1,
    parameter int unsigned       MIN_OFF_CYC = 1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    c3lib_ckg_async_multi_hyst_ctn_if.slave        bus
);
    typedef enum logic [1:0] {
        ST_OFF,
        ST_OFF_HOLD,
        ST_ON,
        ST_ON_HOLD
    } ch_state_e;

    // Hold counter load values; a channel leaves hold after cnt reaches 0,
    // so loading MIN-1 gives exactly MIN cycles in the new level.
    localparam logic [7:0] ON_LOAD  = 8'(MIN_ON_CYC - 1);
    localparam logic [7:0] OFF_LOAD = 8'(MIN_OFF_CYC - 1);

    logic [NUM_CH-1:0] req_s;
    logic [NUM_CH-1:0] en_q;
    logic [NUM_CH-1:0] gclk;
    logic              all_gated_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic       en_d;
        logic [7:0] cnt_q;
        logic [7:0] cnt_d;
        ch_state_e  state;

        c3lib_bitsync #(
            .SYNC_STAGES (SYNC_STAGES),
            .RESET_VAL   (RESET_VAL[i])
        ) u_sync (
            .clk      (clk),
            .rst_n    (rst_n),
            .data_in  (bus.clk_en[i]),
            .data_out (req_s[i])
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                en_q[i] <= RESET_VAL[i];
                cnt_q   <= '0;
            end else begin
                en_q[i] <= en_d;
                cnt_q   <= cnt_d;
            end
        end

        // State is encoded by (en_q, cnt != 0) rather than a separate register.
        always_comb begin
            en_d  = en_q[i];
            cnt_d = cnt_q;
            if (en_q[i]) begin
                state = (cnt_q != '0) ? ST_ON_HOLD : ST_ON;
            end else begin
                state = (cnt_q != '0) ? ST_OFF_HOLD : ST_OFF;
            end
            case (state)
                ST_OFF: begin
                    if (req_s[i]) begin
                        en_d  = 1'b1;
                        cnt_d = ON_LOAD;
                    end
                end
                ST_ON: begin
                    if (!req_s[i]) begin
                        en_d  = 1'b0;
                        cnt_d = OFF_LOAD;
                    end
                end
                default: begin
                    // Either hold state: request ignored until the count expires.
                    cnt_d = cnt_q - 8'd1;
                end
            endcase
        end

        c3lib_ckg_lvt_8x u_ckg (
            .clk       (clk),
            .clk_en    (en_q[i]),
            .tst_en    (bus.tst_en),
            .gated_clk (gclk[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            all_gated_q <= (RESET_VAL == '0);
        end else begin
            all_gated_q <= ~|en_q;
        end
    end

    assign bus.gated_clk  = gclk;
    assign bus.clk_en_ack = en_q;
    assign bus.all_gated  = all_gated_q;
endmodule

// File: tb/tb_c3lib_ckg_async_multi_hyst_ctn.sv
module tb_c3lib_ckg_async_multi_hyst_ctn;
    localparam int unsigned NCH    = 4;
    localparam int unsigned SYNC   = 3;
    localparam logic [3:0]  RSTV   = 4'b0101;
    localparam int          MINON  = 8;
    localparam int          MINOFF = 5;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    c3lib_ckg_async_multi_hyst_ctn_if #(.NUM_CH(NCH)) bus ();

    c3lib_ckg_async_multi_hyst_ctn #(
        .NUM_CH      (NCH),
        .SYNC_STAGES (SYNC),
        .RESET_VAL   (RSTV),
        .MIN_ON_CYC  (MINON),
        .MIN_OFF_CYC (MINOFF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising-edge counters per gated clock.
    for (genvar g = 0; g < NCH; g++) begin : gc
        int n = 0;
        always @(posedge bus.gated_clk[g]) n = n + 1;
    end

    function automatic int gcnt(input int i);
        case (i)
            0: return gc[0].n;
            1: return gc[1].n;
            2: return gc[2].n;
            default: return gc[3].n;
        endcase
    endfunction

    // Reference model: the request seen by the filter is clk_en sampled SYNC
    // edges earlier; an ack may only change once it has held its level for
    // MINON (if high) or MINOFF (if low) cycles.
    logic [3:0] hist[$];
    logic [3:0] ack_m;
    logic       agm;
    int         since[4];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist.delete();
            for (int k = 0; k < int'(SYNC); k++) hist.push_back(RSTV);
            ack_m = RSTV;
            agm   = (RSTV == 4'b0);
            for (int k = 0; k < 4; k++) since[k] = 1000;
        end else begin
            logic [3:0] req;
            logic       agn;
            req = hist.pop_front();
            hist.push_back(bus.clk_en);
            agn = (ack_m == 4'b0);
            for (int k = 0; k < 4; k++) begin
                if (since[k] < 1000) since[k] = since[k] + 1;
                if (req[k] != ack_m[k] && since[k] >= (ack_m[k] ? MINON : MINOFF)) begin
                    ack_m[k] = req[k];
                    since[k] = 0;
                end
            end
            agm = agn;
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        int base[4];
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.clk_en_ack !== RSTV) begin
            failures++;
            $display("FAIL reset_ack: got %b expected %b", bus.clk_en_ack, RSTV);
        end
        checks++;
        if (bus.all_gated !== 1'b0) begin
            failures++;
            $display("FAIL reset_all_gated: got %b expected 0", bus.all_gated);
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) base[i] = gcnt(i);
        for (int e = 0; e < 4; e++) tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (gcnt(i) - base[i] !== (RSTV[i] ? 4 : 0)) begin
                failures++;
                $display("FAIL reset_gclk%0d: got %0d pulses expected %0d", i,
                         gcnt(i) - base[i], RSTV[i] ? 4 : 0);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_latency();
        int base;
        bus.clk_en[1] = 1'b1;
        base = gcnt(1);
        for (int e = 1; e <= 6; e++) begin
            tick();
            checks++;
            if (bus.clk_en_ack[1] !== (e >= int'(SYNC) + 1)) begin
                failures++;
                $display("FAIL lat_on_ack e%0d: got %b expected %b", e,
                         bus.clk_en_ack[1], e >= int'(SYNC) + 1);
            end
            checks++;
            if (gcnt(1) - base !== ((e >= int'(SYNC) + 2) ? e - int'(SYNC) - 1 : 0)) begin
                failures++;
                $display("FAIL lat_on_gclk e%0d: got %0d expected %0d", e, gcnt(1) - base,
                         (e >= int'(SYNC) + 2) ? e - int'(SYNC) - 1 : 0);
            end
        end
        for (int e = 0; e < 12; e++) tick();
        bus.clk_en[1] = 1'b0;
        base = gcnt(1);
        for (int e = 1; e <= 6; e++) begin
            tick();
            checks++;
            if (bus.clk_en_ack[1] !== (e < int'(SYNC) + 1)) begin
                failures++;
                $display("FAIL lat_off_ack e%0d: got %b expected %b", e,
                         bus.clk_en_ack[1], e < int'(SYNC) + 1);
            end
            checks++;
            if (gcnt(1) - base !== ((e < int'(SYNC) + 1) ? e : int'(SYNC) + 1)) begin
                failures++;
                $display("FAIL lat_off_gclk e%0d: got %0d expected %0d", e, gcnt(1) - base,
                         (e < int'(SYNC) + 1) ? e : int'(SYNC) + 1);
            end
        end
    endtask

    task automatic test_min_on();
        int base;
        int on_cyc;
        bus.clk_en[2] = 1'b0;
        for (int e = 0; e < 14; e++) tick();
        checks++;
        if (bus.clk_en_ack[2] !== 1'b0) begin
            failures++;
            $display("FAIL minon_pre: got %b expected 0", bus.clk_en_ack[2]);
        end
        base = gcnt(2);
        on_cyc = 0;
        bus.clk_en[2] = 1'b1;
        tick();
        bus.clk_en[2] = 1'b0;
        for (int e = 0; e < 20; e++) begin
            tick();
            if (bus.clk_en_ack[2]) on_cyc++;
        end
        checks++;
        if (gcnt(2) - base !== MINON) begin
            failures++;
            $display("FAIL minon_pulses: got %0d expected %0d", gcnt(2) - base, MINON);
        end
        checks++;
        if (on_cyc !== MINON) begin
            failures++;
            $display("FAIL minon_ack_cycles: got %0d expected %0d", on_cyc, MINON);
        end
        checks++;
        if (bus.clk_en_ack[2] !== 1'b0) begin
            failures++;
            $display("FAIL minon_end: got %b expected 0", bus.clk_en_ack[2]);
        end
    endtask

    task automatic test_min_off();
        int base;
        int low_cyc;
        int rise_e;
        bus.clk_en[0] = 1'b0;
        tick();
        tick();
        bus.clk_en[0] = 1'b1;
        base = gcnt(0);
        low_cyc = 0;
        rise_e = -1;
        for (int e = 3; e <= 17; e++) begin
            tick();
            if (!bus.clk_en_ack[0]) low_cyc++;
            else if (low_cyc > 0 && rise_e < 0) rise_e = e;
        end
        checks++;
        if (low_cyc !== MINOFF) begin
            failures++;
            $display("FAIL minoff_low_cycles: got %0d expected %0d", low_cyc, MINOFF);
        end
        checks++;
        if (rise_e !== int'(SYNC) + 1 + MINOFF) begin
            failures++;
            $display("FAIL minoff_rise_edge: got %0d expected %0d", rise_e, int'(SYNC) + 1 + MINOFF);
        end
        checks++;
        if (gcnt(0) - base !== 15 - MINOFF) begin
            failures++;
            $display("FAIL minoff_pulses: got %0d expected %0d", gcnt(0) - base, 15 - MINOFF);
        end
    endtask

    task automatic test_tst_en();
        int base[4];
        int waited;
        bus.clk_en = 4'b0;
        waited = 0;
        while (!(bus.clk_en_ack == 4'b0 && bus.all_gated == 1'b1) && waited < 40) begin
            tick();
            waited++;
        end
        checks++;
        if (waited >= 40) begin
            failures++;
            $display("FAIL tst_idle_timeout: got ack %b expected 0000", bus.clk_en_ack);
        end
        bus.tst_en = 1'b1;
        for (int i = 0; i < 4; i++) base[i] = gcnt(i);
        for (int e = 0; e < 5; e++) begin
            tick();
            checks++;
            if (bus.gated_clk !== 4'b0) begin
                failures++;
                $display("FAIL tst_low_phase: got %b expected 0000", bus.gated_clk);
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (gcnt(i) - base[i] !== 5) begin
                failures++;
                $display("FAIL tst_on_gclk%0d: got %0d expected 5", i, gcnt(i) - base[i]);
            end
        end
        checks++;
        if (bus.clk_en_ack !== 4'b0 || bus.all_gated !== 1'b1) begin
            failures++;
            $display("FAIL tst_ack: got ack %b all_gated %b expected 0000 1",
                     bus.clk_en_ack, bus.all_gated);
        end
        bus.tst_en = 1'b0;
        for (int i = 0; i < 4; i++) base[i] = gcnt(i);
        for (int e = 0; e < 3; e++) tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (gcnt(i) - base[i] !== 0) begin
                failures++;
                $display("FAIL tst_off_gclk%0d: got %0d expected 0", i, gcnt(i) - base[i]);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        bus.clk_en = 4'b1000;
        for (int e = 0; e < int'(SYNC) + 1 + 4; e++) tick();
        checks++;
        if (bus.clk_en_ack[3] !== 1'b1) begin
            failures++;
            $display("FAIL midhold_pre: got %b expected 1", bus.clk_en_ack[3]);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.clk_en_ack !== RSTV || bus.all_gated !== 1'b0) begin
            failures++;
            $display("FAIL midhold_async: got ack %b all_gated %b expected %b 0",
                     bus.clk_en_ack, bus.all_gated, RSTV);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 0; e < 20; e++) begin
            if (e == 10) bus.clk_en = 4'b0110;
            tick();
            checks++;
            if (bus.clk_en_ack !== ack_m || bus.all_gated !== agm) begin
                failures++;
                $display("FAIL midhold_post e%0d: got ack %b ag %b expected %b %b", e,
                         bus.clk_en_ack, bus.all_gated, ack_m, agm);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] v;
        logic [3:0] exp_p;
        logic [3:0] got_p;
        int         base[4];
        for (int c = 0; c < 400; c++) begin
            v = bus.clk_en;
            if ($urandom_range(0, 3) == 0) begin
                int idx;
                idx = int'($urandom_range(0, 3));
                v[idx] = ~v[idx];
            end
            bus.clk_en = v;
            bus.tst_en = ($urandom_range(0, 19) == 0);
            exp_p = ack_m | {4{bus.tst_en}};
            for (int i = 0; i < 4; i++) base[i] = gcnt(i);
            tick();
            for (int i = 0; i < 4; i++) got_p[i] = (gcnt(i) - base[i]) == 1;
            checks++;
            if (bus.clk_en_ack !== ack_m) begin
                failures++;
                $display("FAIL rand_ack c%0d: got %b expected %b", c, bus.clk_en_ack, ack_m);
            end
            checks++;
            if (bus.all_gated !== agm) begin
                failures++;
                $display("FAIL rand_all_gated c%0d: got %b expected %b", c, bus.all_gated, agm);
            end
            checks++;
            if (got_p !== exp_p) begin
                failures++;
                $display("FAIL rand_gclk c%0d: got %b expected %b", c, got_p, exp_p);
            end
        end
        bus.tst_en = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b1;
        bus.tst_en = 1'b0;
        bus.clk_en = RSTV;
        test_reset();
        test_latency();
        test_min_on();
        test_min_off();
        test_tst_en();
        test_reset_mid_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/c3lib_ckg_async_multi_hyst_ctn.md
# c3lib_ckg_async_multi_hyst_ctn

Multi-channel positive-edge clock gater with per-channel asynchronous enables, a parametrised synchroniser depth, and minimum-on/minimum-off hysteresis per channel. Each channel synchronises its enable into `clk`, filters it through a small hold-off state machine, and drives one `c3lib_ckg_lvt_8x` cell. A per-channel acknowledge tells the requester when its clock is actually running or stopped. Used wherever several sub-blocks share one root clock and request it independently from foreign domains.

## Interface
- `NUM_CH`, 4: number of gated clock channels (1..32).
- `SYNC_STAGES`, 2: synchroniser flop count per channel (2..4); passed to `c3lib_bitsync`.
- `RESET_VAL`, `{NUM_CH{1'b0}}`: per-channel reset state (bit=0 clock blocked, bit=1 pass-through).
- `MIN_ON_CYC`, 1: minimum cycles a channel stays enabled once enabled (1..255).
- `MIN_OFF_CYC`, 1: minimum cycles a channel stays gated once gated (1..255).

- `clk` in 1: root clock, sole clock domain.
- `rst_n` in 1: asynchronous assert, active-low reset; deassertion is synchronous to `clk` (done upstream).
- `tst_en` in 1: scan/test override; forces every `gated_clk` to toggle.
- `clk_en` in NUM_CH: per-channel enable request, asynchronous to `clk`, level-sensitive.
- `gated_clk` out NUM_CH: per-channel gated clock.
- `clk_en_ack` out NUM_CH: per-channel registered enable driving the gate (1 = clock running).
- `all_gated` out 1: registered; 1 when every `clk_en_ack` bit is 0.

## Operation
- Per channel: `clk_en[i]` → `c3lib_bitsync` (SYNC_STAGES, reset value RESET_VAL[i]) → `req_s[i]`.
- Per-channel state: `en_q` (1 bit) and hold counter `cnt` (8 bits); these encode four states: OFF, OFF_HOLD (en_q=0, cnt≠0), ON, ON_HOLD (en_q=1, cnt≠0).
- ON_HOLD/OFF_HOLD: `cnt` decrements by 1 per cycle; `req_s` is ignored; on reaching 0 the state becomes ON/OFF.
- OFF with `req_s`=1: `en_q`←1 and `cnt`←MIN_ON_CYC−1 (enters ON_HOLD, or ON if MIN_ON_CYC=1).
- ON with `req_s`=0: `en_q`←0 and `cnt`←MIN_OFF_CYC−1 (enters OFF_HOLD, or OFF if MIN_OFF_CYC=1).
- A request that toggles during hold is not lost. After hold, the current `req_s` level is evaluated. A pulse shorter than the synchroniser window may be missed, which is acceptable for a level interface.
- `clk_en_ack[i]` = `en_q[i]`.
- `c3lib_ckg_lvt_8x` per channel: `clk_en`=`en_q[i]`, `tst_en`=`tst_en`. The latch is transparent while `clk` is low, so `gated_clk` never glitches.
- `tst_en`=1 forces all clocks on. The FSMs, counters and acks keep operating normally and do not reflect `tst_en`.
- `all_gated` ← ~|`en_q`, registered (one cycle behind the acks).
- Channels are fully independent, with no shared counter or arbitration.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - `en_q`=RESET_VAL, `cnt`=0, sync flops=RESET_VAL.
  - `clk_en_ack`=RESET_VAL.
  - `all_gated`=(RESET_VAL==0).
  - `gated_clk` follows RESET_VAL once `clk` toggles.
- Enable latency: with `clk_en` stable before edge 1, `req_s`=1 after edge SYNC_STAGES, `en_q`=1 after edge SYNC_STAGES+1, and the first `gated_clk` rising edge coincides with `clk` edge SYNC_STAGES+2.
- Disable latency is symmetric: the last `gated_clk` rising edge is at `clk` edge SYNC_STAGES+1.
- Hold: if `en_q` rises at edge k, it cannot fall before edge k+MIN_ON_CYC, which yields ≥MIN_ON_CYC `gated_clk` pulses. Likewise, at least MIN_OFF_CYC rising edges are suppressed after gating.
- Reset mid-hold aborts the hold immediately; after release, the channel is in OFF/ON per RESET_VAL with no hold.
- `tst_en` takes effect within the current `clk` low phase and does not alter FSM timing.

## Test plan
- Reset: NUM_CH=4, RESET_VAL=4'b0101. Hold `rst_n`=0 and toggle `clk` → `gated_clk`[0],[2] toggle, [1],[3] flat; `clk_en_ack`=4'b0101; `all_gated`=0.
- Latency: SYNC_STAGES=3, raise `clk_en[1]` before edge 1 → `clk_en_ack[1]`=1 after edge 4; first `gated_clk[1]` rise at edge 5; drop it → exactly symmetric stop.
- Min-on hysteresis: MIN_ON_CYC=8, `clk_en[2]` 1-cycle-wide pulse held across the sync window → exactly 8 `gated_clk[2]` pulses, then ack drops.
- Min-off hysteresis: MIN_OFF_CYC=5, drop then re-raise `clk_en[0]` two cycles later → ack low for exactly 5 cycles, then high with no extra delay beyond 1 cycle.
- Test override: `tst_en`=1 with all `clk_en`=0 → every `gated_clk` toggles glitch-free, `clk_en_ack`=0, `all_gated`=1; release → clocks stop at next low phase.
- Reset mid-hold: assert `rst_n` during ON_HOLD (cnt=3) → `clk_en_ack` returns to RESET_VAL asynchronously; after release, no residual hold is observed.
